// File: rtl/stage_sequencer.sv
// Multi-cycle control sequencer: walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB
// with per-instruction MEM/WB skipping, double memory access, stall and boundary halt.
module stage_sequencer #(
  parameter int unsigned FETCH_CYCLES = 2,
  parameter int unsigned MEM_CYCLES   = 2,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt,
  input  logic             dec_mem,
  input  logic             dec_mem2,
  input  logic             dec_wb,
  output logic [4:0]       stage,
  output logic [CNT_W-1:0] stage_cnt,
  output logic             stage_last,
  output logic             instr_done,
  output logic             halted
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] FetchLast = CNT_W'(FETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] MemLast   = CNT_W'(MEM_CYCLES - 1);
  localparam logic [CNT_W-1:0] Mem2Last  = CNT_W'(2 * MEM_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_q, mem_d;
  logic             mem2_q, mem2_d;
  logic             wb_q, wb_d;

  logic [CNT_W-1:0] last_cnt;
  logic             in_stage;
  logic             ends_here;

  // Decode of the current stage: one-hot enable, final count and whether it ends the instruction.
  always_comb begin
    stage     = 5'b0;
    last_cnt  = '0;
    in_stage  = 1'b1;
    ends_here = 1'b0;
    case (state_q)
      StFetch: begin
        stage    = 5'b00001;
        last_cnt = FetchLast;
      end
      StDecode: stage = 5'b00010;
      StExec: begin
        stage     = 5'b00100;
        ends_here = !mem_q && !wb_q;
      end
      StMem: begin
        stage     = 5'b01000;
        last_cnt  = mem2_q ? Mem2Last : MemLast;
        ends_here = !wb_q;
      end
      StWb: begin
        stage     = 5'b10000;
        ends_here = 1'b1;
      end
      default: in_stage = 1'b0;
    endcase
  end

  assign stage_cnt  = cnt_q;
  assign stage_last = rst_n && !stall && in_stage && (cnt_q == last_cnt);
  assign instr_done = stage_last && ends_here;
  assign halted     = (state_q == StHalt);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    mem2_d  = mem2_q;
    wb_d    = wb_q;
    case (state_q)
      StHalt: cnt_d = '0;
      StFetch, StDecode, StExec, StMem, StWb: begin
        if (!stall) begin
          if (stage_last) begin
            cnt_d = '0;
            if (instr_done) begin
              state_d = halt ? StHalt : StFetch;
            end else begin
              case (state_q)
                StFetch: state_d = StDecode;
                StDecode: begin
                  state_d = StExec;
                  mem_d   = dec_mem;
                  mem2_d  = dec_mem & dec_mem2;
                  wb_d    = dec_wb;
                end
                StExec:  state_d = mem_q ? StMem : StWb;
                default: state_d = StWb;
              endcase
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        // Illegal encoding: recover to a clean fetch.
        state_d = StFetch;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      mem_q   <= 1'b0;
      mem2_q  <= 1'b0;
      wb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      mem2_q  <= mem2_d;
      wb_q    <= wb_d;
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: a reference model pushes per-cycle expected outputs into a
// scoreboard queue, popped and compared against the DUT; instruction latencies are also checked.
module tb_stage_sequencer;

  localparam int unsigned FC = 2;
  localparam int unsigned MC = 2;
  localparam int unsigned CW = 4;
  localparam int MF = 0, MD = 1, ME = 2, MM = 3, MW = 4, MH = 5;

  logic          clk = 1'b0;
  logic          rst_n, stall, halt, dec_mem, dec_mem2, dec_wb;
  logic [4:0]    stage;
  logic [CW-1:0] stage_cnt;
  logic          stage_last, instr_done, halted;

  stage_sequencer #(.FETCH_CYCLES(FC), .MEM_CYCLES(MC), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .halt       (halt),
    .dec_mem    (dec_mem),
    .dec_mem2   (dec_mem2),
    .dec_wb     (dec_wb),
    .stage      (stage),
    .stage_cnt  (stage_cnt),
    .stage_last (stage_last),
    .instr_done (instr_done),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] stg;
    logic [3:0] cnt;
    logic       last;
    logic       done;
    logic       hlt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  int   m_st = MF;
  int   m_cnt = 0;
  bit   m_mem, m_mem2, m_wb;
  bit   m_valid = 0;
  bit   obs_done;

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dur(input int st);
    case (st)
      MF:      return FC;
      MM:      return m_mem2 ? 2 * MC : MC;
      default: return 1;
    endcase
  endfunction

  // One clock cycle: drive inputs, predict, compare, then advance the model at the edge.
  task automatic cycle(input bit r, input bit s, input bit h, input bit dm, input bit dm2,
                       input bit dw);
    exp_t e, got;
    bit   last;
    @(negedge clk);
    rst_n = r; stall = s; halt = h; dec_mem = dm; dec_mem2 = dm2; dec_wb = dw;
    #1;
    last = r && !s && (m_st != MH) && (m_cnt == dur(m_st) - 1);
    e.stg  = (m_st == MH) ? 5'b0 : 5'(1 << m_st);
    e.cnt  = 4'(m_cnt);
    e.last = last;
    e.done = last && (m_st == MW || (m_st == MM && !m_wb) || (m_st == ME && !m_mem && !m_wb));
    e.hlt  = (m_st == MH);
    if (m_valid) exp_q.push_back(e);
    obs_done = instr_done;
    if (m_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {stage, stage_cnt, stage_last, instr_done, halted};
      check_val("stage", got.stg, e.stg);
      check_val("stage_cnt", got.cnt, e.cnt);
      check_val("stage_last", got.last, e.last);
      check_val("instr_done", got.done, e.done);
      check_val("halted", got.hlt, e.hlt);
    end
    @(posedge clk);
    if (!r) begin
      m_st = MF; m_cnt = 0; m_mem = 0; m_mem2 = 0; m_wb = 0; m_valid = 1;
    end else if (last) begin
      m_cnt = 0;
      if (e.done) m_st = h ? MH : MF;
      else case (m_st)
        MF: m_st = MD;
        MD: begin m_st = ME; m_mem = dm; m_mem2 = dm && dm2; m_wb = dw; end
        ME: m_st = m_mem ? MM : MW;
        default: m_st = MW;
      endcase
    end else if (m_st != MH && !s) begin
      m_cnt++;
    end
  endtask

  // Runs one instruction from FETCH cnt 0; dec_* are random outside DECODE.
  // halt_mode: 0 never, 1 only during DECODE, 2 always high.
  task automatic run_instr(input bit mem, input bit mem2, input bit wb, input int stalls,
                           input int halt_mode, input int exp_lat, input string tag);
    int lat = 0;
    int left = stalls;
    bit s, h, seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      s = (m_st == ME && left > 0);
      if (s) left--;
      h = (halt_mode == 2) || (halt_mode == 1 && m_st == MD);
      if (m_st == MD) cycle(1, s, h, mem, mem2, wb);
      else cycle(1, s, h, 1'($urandom), 1'($urandom), 1'($urandom));
      lat++;
      seen = obs_done;
    end
    check_val({tag, "_latency"}, seen ? lat : 0, exp_lat);
  endtask

  initial begin
    rst_n = 0; stall = 1; halt = 0; dec_mem = 0; dec_mem2 = 0; dec_wb = 0;
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    run_instr(0, 0, 1, 0, 0, 5, "alu");
    run_instr(0, 0, 0, 0, 0, 4, "branch");
    run_instr(1, 0, 1, 0, 0, 7, "load");
    run_instr(1, 1, 1, 0, 0, 9, "load_mem2");
    run_instr(1, 0, 0, 0, 0, 6, "store");
    run_instr(0, 0, 1, 3, 0, 8, "alu_stall3");
    run_instr(0, 0, 1, 0, 1, 5, "halt_pulse");
    check_val("no_halt_after_pulse", halted, 0);
    // Reset in the middle of a double-access MEM stage.
    for (int i = 0; i < 20 && !(m_st == MM && m_cnt == 1); i++) begin
      if (m_st == MD) cycle(1, 0, 0, 1, 1, 1);
      else cycle(1, 0, 0, 0, 0, 0);
    end
    check_val("reached_mem", stage, 5'b01000);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    run_instr(1, 0, 1, 0, 0, 6, "load_after_reset");
    run_instr(0, 0, 1, 0, 2, 5, "alu_halt");
    for (int i = 0; i < 10; i++)
      cycle(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    check_val("halted_held", halted, 1);
    cycle(0, 0, 0, 0, 0, 0);
    run_instr(0, 0, 1, 0, 0, 5, "alu_after_halt");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
